// File: rtl/phys_reg_file_mp.sv
// Multi-port physical register file with busy/ROB-tag scoreboard, post-reset clearing
// sequencer and registered reads. Define PRF_WB_BYPASS_EN to forward same-cycle CDB data to reads.
module phys_reg_file_mp #(
   parameter int unsigned NUM_PREGS = 64,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned ROB_ID_W  = 5,
   parameter int unsigned N_ALLOC   = 2,
   parameter int unsigned N_WB      = 4,
   parameter int unsigned N_RD      = 6,
   localparam int unsigned PW       = $clog2(NUM_PREGS)
) (
   input  logic                               clk,
   input  logic                               rst,
   output logic                               init_done,
   input  logic [N_ALLOC-1:0]                 alloc_valid,
   input  logic [N_ALLOC-1:0][PW-1:0]         alloc_preg,
   input  logic [N_ALLOC-1:0][ROB_ID_W-1:0]   alloc_rob_id,
   input  logic [N_WB-1:0]                    wb_valid,
   input  logic [N_WB-1:0][PW-1:0]            wb_preg,
   input  logic [N_WB-1:0][DATA_W-1:0]        wb_data,
   input  logic                               flush,
   input  logic [N_RD-1:0]                    rd_valid,
   input  logic [N_RD-1:0][PW-1:0]            rd_preg,
   output logic [N_RD-1:0]                    rd_out_valid,
   output logic [N_RD-1:0][DATA_W-1:0]        rd_data,
   output logic [N_RD-1:0]                    rd_busy,
   output logic [N_RD-1:0][ROB_ID_W-1:0]      rd_rob_id,
   output logic                               wb_conflict
);

   typedef enum logic {S_INIT, S_RUN} state_e;

   state_e                     state_q, state_d;
   logic [PW-1:0]              cnt_q, cnt_d;
   logic                       init_done_q, init_done_d;
   logic                       run_c;

   logic [DATA_W-1:0]          data_q [NUM_PREGS];
   logic [DATA_W-1:0]          data_d [NUM_PREGS];
   logic [NUM_PREGS-1:0]       busy_q, busy_d;
   logic [ROB_ID_W-1:0]        rob_q  [NUM_PREGS];
   logic [ROB_ID_W-1:0]        rob_d  [NUM_PREGS];

   logic [N_RD-1:0]                rd_out_valid_q, rd_out_valid_d;
   logic [N_RD-1:0][DATA_W-1:0]    rd_data_q, rd_data_d;
   logic [N_RD-1:0]                rd_busy_q, rd_busy_d;
   logic [N_RD-1:0][ROB_ID_W-1:0]  rd_rob_id_q, rd_rob_id_d;
   logic                           wb_conflict_q, wb_conflict_d;
   logic                           wb_dup_c;

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // FSM next state: sweep every entry once, then run until reset
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == S_INIT) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == PW'(NUM_PREGS - 1)) state_d = S_RUN;
      end
   end

   // FSM outputs
   always_comb begin
      run_c       = (state_q == S_RUN);
      init_done_d = (state_d == S_RUN);
   end

   // Array update; wb applied highest lane first so the lowest lane lands last
   always_comb begin
      data_d = data_q;
      busy_d = busy_q;
      rob_d  = rob_q;
      if (!run_c) begin
         data_d[cnt_q] = '0;
         busy_d[cnt_q] = 1'b0;
         rob_d[cnt_q]  = '0;
      end else begin
         for (int unsigned k = 0; k < N_WB; k++) begin
            if (wb_valid[N_WB-1-k] && wb_preg[N_WB-1-k] != '0) begin
               data_d[wb_preg[N_WB-1-k]] = wb_data[N_WB-1-k];
               busy_d[wb_preg[N_WB-1-k]] = 1'b0;
            end
         end
         for (int unsigned a = 0; a < N_ALLOC; a++) begin
            if (alloc_valid[a] && alloc_preg[a] != '0) begin
               busy_d[alloc_preg[a]] = 1'b1;
               rob_d[alloc_preg[a]]  = alloc_rob_id[a];
            end
         end
         if (flush) busy_d = '0;
      end
   end

   // Sticky detection of two CDB lanes naming the same real register
   always_comb begin
      wb_dup_c = 1'b0;
      for (int unsigned i = 0; i < N_WB; i++) begin
         for (int unsigned j = i + 1; j < N_WB; j++) begin
            if (wb_valid[i] && wb_valid[j] && wb_preg[i] == wb_preg[j] && wb_preg[i] != '0)
               wb_dup_c = 1'b1;
         end
      end
      wb_conflict_d = wb_conflict_q | (run_c & wb_dup_c);
   end

   // Read sampling; idle ports hold their previous fields
   always_comb begin
      rd_out_valid_d = '0;
      rd_data_d      = rd_data_q;
      rd_busy_d      = rd_busy_q;
      rd_rob_id_d    = rd_rob_id_q;
      for (int unsigned p = 0; p < N_RD; p++) begin
         if (run_c && rd_valid[p]) begin
            rd_out_valid_d[p] = 1'b1;
            rd_data_d[p]      = data_q[rd_preg[p]];
            rd_busy_d[p]      = busy_q[rd_preg[p]];
            rd_rob_id_d[p]    = rob_q[rd_preg[p]];
`ifdef PRF_WB_BYPASS_EN
            for (int unsigned k = 0; k < N_WB; k++) begin
               if (wb_valid[N_WB-1-k] && wb_preg[N_WB-1-k] == rd_preg[p]) begin
                  rd_data_d[p] = wb_data[N_WB-1-k];
                  rd_busy_d[p] = 1'b0;
               end
            end
`else
`endif
            if (rd_preg[p] == '0) begin
               rd_data_d[p]   = '0;
               rd_busy_d[p]   = 1'b0;
               rd_rob_id_d[p] = '0;
            end
         end
      end
   end

   // Storage is cleared by the INIT sweep, so it carries no reset
   always_ff @(posedge clk) begin
      data_q <= data_d;
      busy_q <= busy_d;
      rob_q  <= rob_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         init_done_q    <= 1'b0;
         rd_out_valid_q <= '0;
         rd_data_q      <= '0;
         rd_busy_q      <= '0;
         rd_rob_id_q    <= '0;
         wb_conflict_q  <= 1'b0;
      end else begin
         init_done_q    <= init_done_d;
         rd_out_valid_q <= rd_out_valid_d;
         rd_data_q      <= rd_data_d;
         rd_busy_q      <= rd_busy_d;
         rd_rob_id_q    <= rd_rob_id_d;
         wb_conflict_q  <= wb_conflict_d;
      end
   end

   assign init_done    = init_done_q;
   assign rd_out_valid = rd_out_valid_q;
   assign rd_data      = rd_data_q;
   assign rd_busy      = rd_busy_q;
   assign rd_rob_id    = rd_rob_id_q;
   assign wb_conflict  = wb_conflict_q;

endmodule

// File: tb/tb_phys_reg_file_mp.sv
// Randomized bench for phys_reg_file_mp against a cycle-level array model of the register file.
module tb_phys_reg_file_mp;

   localparam int NP = 64;
   localparam int DW = 32;
   localparam int RW = 5;
   localparam int NA = 2;
   localparam int NW = 4;
   localparam int NR = 6;
   localparam int PW = 6;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    init_done;
   logic [NA-1:0]           alloc_valid;
   logic [NA-1:0][PW-1:0]   alloc_preg;
   logic [NA-1:0][RW-1:0]   alloc_rob_id;
   logic [NW-1:0]           wb_valid;
   logic [NW-1:0][PW-1:0]   wb_preg;
   logic [NW-1:0][DW-1:0]   wb_data;
   logic                    flush;
   logic [NR-1:0]           rd_valid;
   logic [NR-1:0][PW-1:0]   rd_preg;
   logic [NR-1:0]           rd_out_valid;
   logic [NR-1:0][DW-1:0]   rd_data;
   logic [NR-1:0]           rd_busy;
   logic [NR-1:0][RW-1:0]   rd_rob_id;
   logic                    wb_conflict;

   phys_reg_file_mp #(
      .NUM_PREGS(NP), .DATA_W(DW), .ROB_ID_W(RW), .N_ALLOC(NA), .N_WB(NW), .N_RD(NR)
   ) dut (
      .clk(clk), .rst(rst), .init_done(init_done),
      .alloc_valid(alloc_valid), .alloc_preg(alloc_preg), .alloc_rob_id(alloc_rob_id),
      .wb_valid(wb_valid), .wb_preg(wb_preg), .wb_data(wb_data), .flush(flush),
      .rd_valid(rd_valid), .rd_preg(rd_preg), .rd_out_valid(rd_out_valid),
      .rd_data(rd_data), .rd_busy(rd_busy), .rd_rob_id(rd_rob_id),
      .wb_conflict(wb_conflict)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference state
   logic [DW-1:0] m_data [NP];
   logic          m_busy [NP];
   logic [RW-1:0] m_rob  [NP];
   logic          m_conf;
   int            init_left;

   // Expected registered read outputs
   logic          e_valid [NR];
   logic [DW-1:0] e_data  [NR];
   logic          e_busy  [NR];
   logic [RW-1:0] e_rob   [NR];
   logic          e_done;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clear_inputs();
      alloc_valid = '0; alloc_preg = '0; alloc_rob_id = '0;
      wb_valid = '0; wb_preg = '0; wb_data = '0; flush = 1'b0;
      rd_valid = '0; rd_preg = '0;
   endtask

   task automatic rand_inputs();
      for (int p = 0; p < NR; p++)
         rd_preg[p] = ($urandom_range(0, 3) == 0) ? PW'($urandom) : PW'($urandom_range(0, 15));
      rd_valid = NR'($urandom);
      for (int a = 0; a < NA; a++) begin
         alloc_preg[a]   = PW'($urandom_range(0, 15));
         alloc_rob_id[a] = RW'($urandom);
      end
      alloc_valid = NA'($urandom);
      for (int l = 0; l < NW; l++) begin
         wb_preg[l] = PW'($urandom_range(0, 15));
         wb_data[l] = DW'($urandom);
      end
      wb_valid = NW'($urandom);
      flush    = ($urandom_range(0, 15) == 0);
   endtask

   task automatic check_outputs(input string pfx);
      check_val({pfx, "init_done"}, 64'(init_done), 64'(e_done));
      check_val({pfx, "wb_conflict"}, 64'(wb_conflict), 64'(m_conf));
      for (int p = 0; p < NR; p++) begin
         check_val($sformatf("%srd_out_valid[%0d]", pfx, p), 64'(rd_out_valid[p]), 64'(e_valid[p]));
         check_val($sformatf("%srd_data[%0d]", pfx, p), 64'(rd_data[p]), 64'(e_data[p]));
         check_val($sformatf("%srd_busy[%0d]", pfx, p), 64'(rd_busy[p]), 64'(e_busy[p]));
         if (e_busy[p])
            check_val($sformatf("%srd_rob_id[%0d]", pfx, p), 64'(rd_rob_id[p]), 64'(e_rob[p]));
      end
   endtask

   // One clock: predict outputs and next state from current inputs, then compare
   task automatic step();
      logic written [NP];
      int   pr;
      bit   hit;
      if (init_left > 0) begin
         for (int p = 0; p < NR; p++) e_valid[p] = 1'b0;
         init_left--;
      end else begin
         for (int p = 0; p < NR; p++) begin
            e_valid[p] = rd_valid[p];
            if (rd_valid[p]) begin
               pr = int'(rd_preg[p]);
               if (pr == 0) begin
                  e_data[p] = '0; e_busy[p] = 1'b0; e_rob[p] = '0;
               end else begin
                  e_data[p] = m_data[pr]; e_busy[p] = m_busy[pr]; e_rob[p] = m_rob[pr];
`ifdef PRF_WB_BYPASS_EN
                  hit = 1'b0;
                  for (int l = 0; l < NW; l++)
                     if (!hit && wb_valid[l] && int'(wb_preg[l]) == pr) begin
                        e_data[p] = wb_data[l]; e_busy[p] = 1'b0; hit = 1'b1;
                     end
`else
                  hit = 1'b0;
`endif
               end
            end
         end
         for (int i = 0; i < NW; i++)
            for (int j = i + 1; j < NW; j++)
               if (wb_valid[i] && wb_valid[j] && wb_preg[i] == wb_preg[j] && wb_preg[i] != 0)
                  m_conf = 1'b1;
         for (int k = 0; k < NP; k++) written[k] = 1'b0;
         for (int l = 0; l < NW; l++) begin
            pr = int'(wb_preg[l]);
            if (wb_valid[l] && pr != 0 && !written[pr]) begin
               m_data[pr] = wb_data[l]; m_busy[pr] = 1'b0; written[pr] = 1'b1;
            end
         end
         for (int a = 0; a < NA; a++) begin
            pr = int'(alloc_preg[a]);
            if (alloc_valid[a] && pr != 0) begin
               m_busy[pr] = 1'b1; m_rob[pr] = alloc_rob_id[a];
            end
         end
         if (flush) for (int k = 0; k < NP; k++) m_busy[k] = 1'b0;
      end
      e_done = (init_left == 0);
      @(posedge clk);
      #1;
      check_outputs("");
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_inputs();
      #1;
      for (int k = 0; k < NP; k++) begin
         m_data[k] = '0; m_busy[k] = 1'b0; m_rob[k] = '0;
      end
      for (int p = 0; p < NR; p++) begin
         e_valid[p] = 1'b0; e_data[p] = '0; e_busy[p] = 1'b0; e_rob[p] = '0;
      end
      m_conf = 1'b0; e_done = 1'b0; init_left = NP;
      check_outputs("rst_");
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      do_reset();
      // Traffic during INIT must be ignored
      for (int c = 0; c < NP; c++) begin
         rand_inputs();
         step();
      end
      clear_inputs(); rd_valid[0] = 1'b1; rd_preg[0] = 6'd5;
      step();
      check_val("p5_after_init", 64'(rd_data[0]), 64'd0);

      clear_inputs(); alloc_valid[0] = 1'b1; alloc_preg[0] = 6'd7; alloc_rob_id[0] = 5'd3;
      step();
      clear_inputs(); rd_valid[1] = 1'b1; rd_preg[1] = 6'd7;
      step();
      check_val("p7_busy", 64'(rd_busy[1]), 64'd1);
      check_val("p7_rob", 64'(rd_rob_id[1]), 64'd3);
      clear_inputs(); wb_valid[0] = 1'b1; wb_preg[0] = 6'd7; wb_data[0] = 32'hDEADBEEF;
      step();
      clear_inputs(); rd_valid[0] = 1'b1; rd_preg[0] = 6'd7;
      step();
      check_val("p7_data", 64'(rd_data[0]), 64'hDEADBEEF);

      clear_inputs(); wb_valid[1] = 1'b1; wb_preg[1] = 6'd9; wb_data[1] = 32'h99;
      step();
      clear_inputs(); wb_valid[0] = 1'b1; wb_preg[0] = 6'd9; wb_data[0] = 32'h55;
      rd_valid[2] = 1'b1; rd_preg[2] = 6'd9;
      step();
`ifdef PRF_WB_BYPASS_EN
      check_val("p9_same_cycle", 64'(rd_data[2]), 64'h55);
`else
      check_val("p9_same_cycle", 64'(rd_data[2]), 64'h99);
`endif

      clear_inputs(); wb_valid = 4'b1010;
      wb_preg[1] = 6'd12; wb_data[1] = 32'h11; wb_preg[3] = 6'd12; wb_data[3] = 32'h33;
      step();
      check_val("conflict_set", 64'(wb_conflict), 64'd1);
      clear_inputs(); rd_valid[3] = 1'b1; rd_preg[3] = 6'd12;
      step();
      check_val("p12_low_lane", 64'(rd_data[3]), 64'h11);

      clear_inputs(); alloc_valid[1] = 1'b1; alloc_preg[1] = 6'd4; alloc_rob_id[1] = 5'd9;
      wb_valid[2] = 1'b1; wb_preg[2] = 6'd4; wb_data[2] = 32'h44;
      step();
      clear_inputs(); rd_valid[4] = 1'b1; rd_preg[4] = 6'd4;
      step();
      check_val("p4_alloc_wins", 64'(rd_busy[4]), 64'd1);

      clear_inputs(); alloc_valid = 2'b11; alloc_preg[0] = 6'd10; alloc_preg[1] = 6'd11;
      step();
      clear_inputs(); flush = 1'b1; alloc_valid[0] = 1'b1; alloc_preg[0] = 6'd12;
      step();
      clear_inputs(); rd_valid = 6'b000111;
      rd_preg[0] = 6'd10; rd_preg[1] = 6'd11; rd_preg[2] = 6'd12;
      step();
      check_val("flush_p12", 64'(rd_busy[2]), 64'd0);

      clear_inputs(); alloc_valid[0] = 1'b1; alloc_preg[0] = 6'd0; alloc_rob_id[0] = 5'd1;
      wb_valid[0] = 1'b1; wb_preg[0] = 6'd0; wb_data[0] = 32'hFFFF;
      step();
      clear_inputs(); rd_valid[5] = 1'b1; rd_preg[5] = 6'd0;
      step();
      check_val("p0_data", 64'(rd_data[5]), 64'd0);

      for (int c = 0; c < 500; c++) begin
         rand_inputs();
         step();
      end

      do_reset();
      for (int c = 0; c < NP + 200; c++) begin
         rand_inputs();
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/phys_reg_file_mp.md
# phys_reg_file_mp

Multi-port physical register file with a per-register busy/ROB-tag scoreboard, parametrised in register count, data width, allocate ports, writeback (CDB) ports and read ports. Sits between rename/dispatch, the CDB and the functional-unit issue paths. Dispatch uses it to mark destinations busy, the CDB uses it to write results, and dispatch and issue use it to read operands. Adds three things to the earlier single-configuration file: a post-reset clearing sequencer, registered reads, and detection of writeback-port conflicts.

## Interface
Parameters:
- NUM_PREGS, 64, physical register count; power of two ≥ 8; PW = $clog2(NUM_PREGS).
- DATA_W, 32, register data width.
- ROB_ID_W, 5, ROB tag width.
- N_ALLOC, 2, allocate ports (superscalar dispatch width).
- N_WB, 4, writeback ports (CDB lanes).
- N_RD, 6, independent read ports.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- init_done  out  1  high once the clearing sequence completes.
- alloc_valid  in  N_ALLOC  per-port allocate strobe.
- alloc_preg  in  N_ALLOC×PW  destination register to mark busy.
- alloc_rob_id  in  N_ALLOC×ROB_ID_W  producer tag stored with busy.
- wb_valid  in  N_WB  per-lane writeback strobe.
- wb_preg  in  N_WB×PW  register written.
- wb_data  in  N_WB×DATA_W  result value.
- flush  in  1  clears every busy bit (misprediction recovery).
- rd_valid  in  N_RD  read request.
- rd_preg  in  N_RD×PW  register read.
- rd_out_valid  out  N_RD  response valid.
- rd_data  out  N_RD×DATA_W  register value.
- rd_busy  out  N_RD  register still awaiting its producer.
- rd_rob_id  out  N_RD×ROB_ID_W  producer tag; meaningful only when rd_busy=1.
- wb_conflict  out  1  sticky: two WB lanes wrote the same register in one cycle.

## Operation
- State per entry: data[DATA_W], busy, rob_id[ROB_ID_W].
- FSM:
  - INIT: a PW-bit counter clears one entry per cycle (data=0, busy=0, rob_id=0). On the cycle the counter equals NUM_PREGS-1, the next state is RUN.
  - RUN: normal operation. The block stays in RUN until rst.
- During INIT, all alloc, wb, flush and rd inputs are ignored; rd_out_valid=0.
- Register 0 is hardwired: every read returns data=0 and busy=0. Allocates and writebacks targeting register 0 are dropped.
- Writeback: data[p] <= wb_data and busy[p] <= 0.
- Allocate: busy[p] <= 1 and rob_id[p] <= alloc_rob_id.
- Same register in the same cycle: allocate beats writeback for busy and rob_id; the data is still written.
- Flush: busy <= 0 for all entries. Flush beats a same-cycle allocate. A same-cycle writeback still writes data.
- Multiple WB lanes naming the same non-zero register: the lowest lane index wins, and wb_conflict is set. It stays set until rst.
- Two allocate ports naming the same register: the highest port index wins rob_id. This is not an error.
- Read response fields are sampled into output registers: data, busy and rob_id of rd_preg.

## Timing
- Reset values: init_done=0, rd_out_valid=0, rd_data=0, rd_busy=0, rd_rob_id=0, wb_conflict=0. The FSM enters INIT and the counter is 0.
- Reset asserted mid-operation restarts INIT. init_done rises exactly NUM_PREGS cycles after rst deasserts.
- Read latency is 1 cycle: a request in cycle N gives rd_out_valid plus fields in cycle N+1. A port with rd_valid=0 gives rd_out_valid=0 in N+1 and holds its previous data.
- Allocate in cycle N: a read requested in N+1 sees busy=1. A read requested in N sees the pre-allocate state; allocates are never bypassed.
- Writeback or flush in cycle N updates the array at the edge ending N.
- Reads have no backpressure; every port is serviced every cycle.

## Configuration
- PRF_WB_BYPASS_EN defined: a read requested in cycle N whose rd_preg matches a valid wb_preg in N returns that wb_data (lowest matching lane) with busy=0 in N+1.
- PRF_WB_BYPASS_EN undefined: the same read returns the array contents from before the write. The written value is visible to requests from N+1 onward.

## Test plan
- Reset-init check:
  - Stimulus: NUM_PREGS=64; deassert rst; issue reads during INIT.
  - Required: init_done rises at cycle 64; every read returns rd_out_valid=0 until then.
  - Then read p5: data=0, busy=0.
- Allocate then writeback:
  - Stimulus: alloc p7 with rob_id 3; next cycle read p7.
  - Required: busy=1, rob_id=3.
  - Then wb p7=0xDEADBEEF; next-cycle read returns 0xDEADBEEF, busy=0.
- Same-cycle read and writeback:
  - Stimulus: wb p9=0x55 and read p9 in the same cycle.
  - Required with PRF_WB_BYPASS_EN: 0x55, busy=0.
  - Required without it: the previous value.
- Conflicts and priority:
  - Lanes 1 and 3 write p12 (0x11 and 0x33) in the same cycle → data=0x11, wb_conflict=1, held until rst.
  - Alloc plus wb on p4 in the same cycle → busy=1.
- Flush:
  - Stimulus: alloc p10, p11; flush together with alloc p12.
  - Required: reads of p10, p11, p12 all return busy=0.
- Register 0:
  - Stimulus: alloc p0 and wb p0=0xFFFF, then read p0.
  - Required: data=0, busy=0.
  - Reset pulse mid-run: init_done drops and the FSM restarts INIT.
